// File: rtl/sar_pkg.sv
// Shared constants for the SAR comparator controller: FSM state encoding,
// synchronizer depth and majority-vote sample count.
package sar_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int SYNC_STAGES = 2;
  localparam int MAJ_SAMPLES = 3;

endpackage

// File: rtl/cmp_sync.sv
// Multi-flop synchronizer bringing the asynchronous comparator decision into
// the clk domain. Depth comes from SYNC_STAGES (2).
module cmp_sync
  import sar_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // shift the raw input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cmp_sar_ctrl.sv
// Successive-approximation controller for an external DAC + comparator.
// Each bit trial: SETTLE (SETTLE_CYC+2 cycles, covers DAC settling and the
// synchronizer delay) then SAMPLE. Optional macro CMP_MAJORITY_EN stretches
// SAMPLE to 3 cycles and decides each bit by a 2-of-3 vote.
module cmp_sar_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmp_in,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result
);

  localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [N_BITS-1:0] MSB_CODE = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [4:0] SETTLE_LD = 5'(SETTLE_CYC + 1);

  logic [1:0]        r_state;
  logic [IW-1:0]     r_idx;
  logic [4:0]        r_cnt;
  logic [N_BITS-1:0] r_dac;
  logic [N_BITS-1:0] r_result;

  logic              w_cmp;
  logic              w_bit;
  logic              w_last_sample;
  logic [N_BITS-1:0] w_dec;
  logic [N_BITS-1:0] w_next;

  cmp_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (cmp_in),
    .o_q   (w_cmp)
  );

`ifdef CMP_MAJORITY_EN
  logic [1:0] r_votes;

  // keep the two earlier samples of the window; the third is taken live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_votes <= '0;
    else if (r_state == ST_SAMPLE) r_votes <= {r_votes[0], w_cmp};
  end

  assign w_bit = (r_votes[1] & r_votes[0]) | (r_votes[1] & w_cmp) |
                 (r_votes[0] & w_cmp);
  assign w_last_sample = (r_cnt == 5'd0);
`else
  assign w_bit = w_cmp;
  assign w_last_sample = 1'b1;
`endif

  // current trial bit resolved, and the code with the next lower bit raised
  always_comb begin
    w_dec = r_dac;
    w_dec[r_idx] = w_bit;
    w_next = w_dec;
    if (r_idx != '0) w_next[r_idx - IW'(1)] = 1'b1;
  end

  // conversion sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_dac    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= IW'(N_BITS - 1);
            r_dac   <= MSB_CODE;
            r_cnt   <= SETTLE_LD;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 5'd0) begin
            r_state <= ST_SAMPLE;
`ifdef CMP_MAJORITY_EN
            r_cnt   <= 5'(MAJ_SAMPLES - 1);
`endif
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        ST_SAMPLE: begin
          if (w_last_sample) begin
            if (r_idx != '0) begin
              r_dac   <= w_next;
              r_idx   <= r_idx - IW'(1);
              r_cnt   <= SETTLE_LD;
              r_state <= ST_SETTLE;
            end else begin
              // result goes valid together with the done pulse
              r_dac    <= w_dec;
              r_result <= w_dec;
              r_state  <= ST_DONE;
            end
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dac_code = r_dac;
  assign result   = r_result;
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);

endmodule
